chess_time_display: RTL and testbench
=====================================

Name: chess_time_display

Overview:
- Downstream consumer of chess_clock: takes player1_time/player2_time (seconds, 16-bit) and the two flag outputs.
- Converts each time to MM:SS BCD with a sequential divide-by-subtraction FSM.
- Drives an 8-digit multiplexed, active-low 7-segment display: player 1 on the left four digits, player 2 on the right four.
- Blinks a flagged player's digits.

Parameters:
- REFRESH_DIV, 1000: clk cycles each digit stays selected (≥1).
- BLINK_DIV, 25000000: clk cycles per blink half-period (≥1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- player1_time  input  16  player 1 remaining seconds
- player2_time  input  16  player 2 remaining seconds
- player1_flag  input  1  player 1 out of time
- player2_flag  input  1  player 2 out of time
- blank  input  1  1 = all digits off
- an  output  8  digit enables, active-low, one-hot; an[7] = leftmost
- seg  output  7  segments gfedcba, active-low; seg[6]=g, seg[0]=a
- dp  output  1  decimal point, active-low; used as colon
- p1_digits  output  16  player 1 BCD {min_tens, min_units, sec_tens, sec_units}
- p2_digits  output  16  player 2 BCD, same layout
- conv_done  output  1  1-cycle pulse when a player's digits commit

Behaviour:
- Reset values (async): an=8'hFF, seg=7'h7F, dp=1, p1_digits=p2_digits=0, conv_done=0, digit index=0, refresh/blink counters=0, blink phase=ON, converter in LOAD for player 1.
- The converter runs continuously and alternates players: P1, P2, P1, …
- LOAD (1 cycle): snapshot the selected player's time, clamped to 5999 when ≥6000. Set w=snapshot, m=0, mt=0, st=0.
- MIN (1 cycle per step): if w≥60, then w−=60 and m+=1; else go to MTEN.
- MTEN: if m≥10, then m−=10 and mt+=1; else go to STEN.
- STEN: if w≥10, then w−=10 and st+=1; else go to COMMIT.
- COMMIT (1 cycle): write {mt,m,st,w} to that player's digit register and pulse conv_done. Toggle player and return to LOAD.
- Worst case per player: 1+100+10+6+1 = 118 cycles, reached at 5999.
- Inputs that change after LOAD do not affect the conversion in flight; they are picked up at the next LOAD for that player.
- Digit registers only change at COMMIT, so a display digit never shows a partial result.
- Refresh: counter 0..REFRESH_DIV−1. On wrap, the digit index advances 0..7 and wraps 7→0.
- Index i drives an = ~(8'h80 >> i), registered.
- Index 0..3 show p1 digits min_tens..sec_units; index 4..7 show p2 digits.
- dp=0 on index 1 and 5; otherwise dp=1.
- Segment codes 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). Any other BCD value gives 7F.
- Blink: counter 0..BLINK_DIV−1 toggles the phase on wrap.
- When the blink phase is OFF and the flag of the player owning the current index is 1, that digit gets an=8'hFF, seg=7F, dp=1. The other player is unaffected.
- Both flags set: both halves blink in phase.
- blank=1 forces an=8'hFF, seg=7F, dp=1. The counters and converter keep running.
- All outputs are registered; an, seg and dp change together one cycle after an index change.

Decomposition:
- Package chess_display_pkg holds:
  - seven-segment code constants SEG_0..SEG_9 and SEG_OFF;
  - TIME_CLAMP=5999;
  - converter state encoding LOAD, MIN, MTEN, STEN, COMMIT.
- Sub-module time_to_bcd holds the converter FSM, the clamp and the player-alternation logic.
- The top level keeps the refresh counter, blink counter, digit mux and segment decode.

Test Plan:
- Reset: hold reset mid-run → an=FF, seg=7F, dp=1, p1_digits=p2_digits=0000, conv_done=0, all asynchronously before the next clk edge.
- Conversion: p1=125, p2=0 → after two conv_done pulses, p1_digits=16'h0205 and p2_digits=16'h0000. p1=59 → 0059; p1=60 → 0100.
- Clamp and latency: p1=7000, p2=5999 → both 16'h9959. P2 conv_done arrives exactly 118 cycles after its LOAD cycle.
- Multiplex: REFRESH_DIV=4, p1=125 →
  - an steps 7F,BF,DF,EF,F7,FB,FD,FE, every 4 cycles;
  - seg on the first four digits = 40,24,40,12;
  - dp=0 only while an=BF or an=FD.
- Blink: BLINK_DIV=16, player1_flag=1 → in OFF phase, digits 0–3 show an=FF/seg=7F and digits 4–7 show normally. In ON phase all 8 show. blank=1 → an=FF constantly.
- Robustness:
  - change p1 from 3000 to 10 during MIN → committed value is 5000, then the next P1 commit is 0010;
  - reset asserted during MIN → clean restart, next commit correct.

Source files
------------

// File: rtl/chess_display_pkg.sv
// Shared constants and types for the chess clock display: segment codes,
// the time clamp and the BCD converter state encoding.
package chess_display_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Largest time that still fits in MM:SS (99:59)
  localparam logic [15:0] TIME_CLAMP = 16'd5999;

  typedef enum logic [2:0] {
    LOAD,
    MIN,
    MTEN,
    STEN,
    COMMIT
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] code;
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/chess_time_display_if.sv
// Bus carrying both players' remaining time and out-of-time flags from
// the chess clock core to the display.
interface chess_time_display_if;

  logic [15:0] player1_time;
  logic [15:0] player2_time;
  logic        player1_flag;
  logic        player2_flag;

  modport master (
    output player1_time,
    output player2_time,
    output player1_flag,
    output player2_flag
  );

  modport slave (
    input player1_time,
    input player2_time,
    input player1_flag,
    input player2_flag
  );

endinterface

// File: rtl/time_to_bcd.sv
// Sequential seconds-to-MM:SS BCD converter using repeated subtraction,
// alternating between the two players forever.
module time_to_bcd
  import chess_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] player1_time,
  input  logic [15:0] player2_time,
  output logic [15:0] p1_digits,
  output logic [15:0] p2_digits,
  output logic        conv_done
);

  conv_state_t state, next_state;
  logic        player;
  logic [15:0] w;
  logic [6:0]  m;
  logic [3:0]  mt;
  logic [3:0]  st;
  logic [15:0] sel_time;
  logic [15:0] clamped;
  logic        commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    next_state = MIN;
      MIN:     if (w < 16'd60) next_state = MTEN;
      MTEN:    if (m < 7'd10)  next_state = STEN;
      STEN:    if (w < 16'd10) next_state = COMMIT;
      COMMIT:  next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_comb begin
    sel_time = player ? player2_time : player1_time;
    clamped  = (sel_time > TIME_CLAMP) ? TIME_CLAMP : sel_time;
    commit   = (state == COMMIT);
  end

  // The working registers are private; the digit registers only move at
  // COMMIT so the display never shows a half-finished conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player    <= 1'b0;
      w         <= '0;
      m         <= '0;
      mt        <= '0;
      st        <= '0;
      p1_digits <= '0;
      p2_digits <= '0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= commit;
      case (state)
        LOAD: begin
          w  <= clamped;
          m  <= '0;
          mt <= '0;
          st <= '0;
        end
        MIN: if (w >= 16'd60) begin
          w <= w - 16'd60;
          m <= m + 7'd1;
        end
        MTEN: if (m >= 7'd10) begin
          m  <= m - 7'd10;
          mt <= mt + 4'd1;
        end
        STEN: if (w >= 16'd10) begin
          w  <= w - 16'd10;
          st <= st + 4'd1;
        end
        COMMIT: begin
          if (player) p2_digits <= {mt, m[3:0], st, w[3:0]};
          else        p1_digits <= {mt, m[3:0], st, w[3:0]};
          player <= ~player;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/chess_time_display.sv
// Eight-digit multiplexed 7-segment display for both chess clock players,
// with per-player blinking when a flag falls and a global blank.
module chess_time_display
  import chess_display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  chess_time_display_if.slave   time_bus,
  input  logic                  blank,
  output logic [7:0]            an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [15:0]           p1_digits,
  output logic [15:0]           p2_digits,
  output logic                  conv_done
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic [2:0]    idx;
  logic          blink_on;
  logic          refresh_wrap;
  logic          blink_wrap;
  logic [3:0]    digit;
  logic          owner_flag;
  logic          hide;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  time_to_bcd u_conv (
    .clk          (clk),
    .reset        (reset),
    .player1_time (time_bus.player1_time),
    .player2_time (time_bus.player2_time),
    .p1_digits    (p1_digits),
    .p2_digits    (p2_digits),
    .conv_done    (conv_done)
  );

  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign blink_wrap   = (blink_cnt == BW'(BLINK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
      idx         <= '0;
      blink_on    <= 1'b1;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + BW'(1);
      if (refresh_wrap) idx <= idx + 3'd1;
      if (blink_wrap) blink_on <= ~blink_on;
    end
  end

  // Left half belongs to player 1, right half to player 2; the colon sits
  // after each player's minutes digit.
  always_comb begin
    digit = 4'h0;
    case (idx)
      3'd0: digit = p1_digits[15:12];
      3'd1: digit = p1_digits[11:8];
      3'd2: digit = p1_digits[7:4];
      3'd3: digit = p1_digits[3:0];
      3'd4: digit = p2_digits[15:12];
      3'd5: digit = p2_digits[11:8];
      3'd6: digit = p2_digits[7:4];
      3'd7: digit = p2_digits[3:0];
      default: digit = 4'h0;
    endcase
    owner_flag = idx[2] ? time_bus.player2_flag : time_bus.player1_flag;
    hide       = blank || (!blink_on && owner_flag);
    an_next    = hide ? 8'hFF : ~(8'h80 >> idx);
    seg_next   = hide ? SEG_OFF : seg_decode(digit);
    dp_next    = hide ? 1'b1 : (idx[1:0] != 2'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_chess_time_display.sv
// Directed self-checking bench for chess_time_display: conversion values,
// latency, clamp, multiplexing, blinking, blanking and reset robustness.
module tb_chess_time_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        blank = 1'b0;
  logic [7:0]  an, an_b;
  logic [6:0]  seg, seg_b;
  logic        dp, dp_b;
  logic [15:0] p1_digits, p2_digits, p1_digits_b, p2_digits_b;
  logic        conv_done, conv_done_b;

  int n_cmp = 0;
  int n_fail = 0;
  int cycles;

  // Expected segment codes per digit index for p1=125 (02:05), p2=5999 (99:59)
  logic [6:0] seg_tab [8] = '{7'h40, 7'h24, 7'h40, 7'h12, 7'h10, 7'h10, 7'h12, 7'h10};

  chess_time_display_if bus ();

  chess_time_display #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .time_bus  (bus.slave),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .p1_digits (p1_digits),
    .p2_digits (p2_digits),
    .conv_done (conv_done)
  );

  // Refresh period not a divisor of the blink period, so the off phase
  // also lands on player 1's digits
  chess_time_display #(.REFRESH_DIV(5), .BLINK_DIV(16)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .time_bus  (bus.slave),
    .blank     (blank),
    .an        (an_b),
    .seg       (seg_b),
    .dp        (dp_b),
    .p1_digits (p1_digits_b),
    .p2_digits (p2_digits_b),
    .conv_done (conv_done_b)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] t1, input logic [15:0] t2,
                                input logic f1, input logic f2, input logic blk);
    bus.player1_time = t1;
    bus.player2_time = t2;
    bus.player1_flag = f1;
    bus.player2_flag = f2;
    blank = blk;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(output int n);
    bit found = 0;
    n = 0;
    while (!found && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (conv_done) found = 1;
    end
    check_output("conv_done_seen", 32'(found), 32'd1);
  endtask

  // Value visible after the n-th clock edge since reset release
  task automatic expect_disp(input int n, input int r, input bit f1, input bit f2, input bit blk,
                             output logic [7:0] an_e, output logic [6:0] seg_e, output logic dp_e);
    int  i;
    bit  off, hide;
    logic [7:0] one_hot;
    i = ((n - 1) / r) % 8;
    off = (((n - 1) / 16) % 2) == 1;
    hide = blk || (off && ((i < 4) ? f1 : f2));
    one_hot = 8'h80 >> i;
    an_e  = hide ? 8'hFF : ~one_hot;
    seg_e = hide ? 7'h7F : seg_tab[i];
    dp_e  = hide ? 1'b1 : ((i == 1 || i == 5) ? 1'b0 : 1'b1);
  endtask

  task automatic scan_check(input string tag, input bit f1, input bit f2, input bit blk);
    logic [7:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    apply_stimulus(16'd125, 16'd5999, f1, f2, blk);
    for (int n = 1; n <= 356; n++) begin
      @(posedge clk);
      #1;
      if (n >= 260) begin
        expect_disp(n, 4, f1, f2, blk, an_e, seg_e, dp_e);
        check_output({tag, "_an"}, 32'(an), 32'(an_e));
        check_output({tag, "_seg"}, 32'(seg), 32'(seg_e));
        check_output({tag, "_dp"}, 32'(dp), 32'(dp_e));
        expect_disp(n, 5, f1, f2, blk, an_e, seg_e, dp_e);
        check_output({tag, "_an_b"}, 32'(an_b), 32'(an_e));
        check_output({tag, "_seg_b"}, 32'(seg_b), 32'(seg_e));
        check_output({tag, "_dp_b"}, 32'(dp_b), 32'(dp_e));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.player1_time = '0;
    bus.player2_time = '0;
    bus.player1_flag = 1'b0;
    bus.player2_flag = 1'b0;

    // Asynchronous reset in the middle of a run
    apply_stimulus(16'd125, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    check_output("pre_reset_p1", 32'(p1_digits), 32'h0205);
    check_output("pre_reset_an", 32'(an), 32'hF7);
    #3 reset = 1'b1;
    #1;
    check_output("rst_an", 32'(an), 32'hFF);
    check_output("rst_seg", 32'(seg), 32'h7F);
    check_output("rst_dp", 32'(dp), 32'd1);
    check_output("rst_p1", 32'(p1_digits), 32'h0);
    check_output("rst_p2", 32'(p2_digits), 32'h0);
    check_output("rst_done", 32'(conv_done), 32'd0);

    apply_stimulus(16'd125, 16'd0, 1'b0, 1'b0, 1'b0);
    wait_done(cycles);
    wait_done(cycles);
    check_output("conv_125", 32'(p1_digits), 32'h0205);
    check_output("conv_p2_0", 32'(p2_digits), 32'h0000);
    @(posedge clk);
    #1;
    check_output("done_pulse_width", 32'(conv_done), 32'd0);

    apply_stimulus(16'd59, 16'd3599, 1'b0, 1'b0, 1'b0);
    wait_done(cycles);
    wait_done(cycles);
    check_output("conv_59", 32'(p1_digits), 32'h0059);
    check_output("conv_3599", 32'(p2_digits), 32'h5959);

    apply_stimulus(16'd60, 16'd600, 1'b0, 1'b0, 1'b0);
    wait_done(cycles);
    wait_done(cycles);
    check_output("conv_60", 32'(p1_digits), 32'h0100);
    check_output("conv_600", 32'(p2_digits), 32'h1000);

    // Clamp and worst-case latency
    apply_stimulus(16'd7000, 16'd5999, 1'b0, 1'b0, 1'b0);
    wait_done(cycles);
    check_output("p1_latency", 32'(cycles), 32'd118);
    check_output("clamp_7000", 32'(p1_digits), 32'h9959);
    wait_done(cycles);
    check_output("p2_latency", 32'(cycles), 32'd118);
    check_output("conv_5999", 32'(p2_digits), 32'h9959);

    scan_check("mux", 1'b0, 1'b0, 1'b0);
    scan_check("blink_p1", 1'b1, 1'b0, 1'b0);
    scan_check("blink_p2", 1'b0, 1'b1, 1'b0);
    scan_check("blink_both", 1'b1, 1'b1, 1'b0);
    scan_check("blank", 1'b0, 1'b0, 1'b1);
    check_output("blank_conv_runs", 32'(p2_digits), 32'h9959);
    blank = 1'b0;

    // Input change during MIN does not disturb the conversion in flight
    apply_stimulus(16'd3000, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.player1_time = 16'd10;
    wait_done(cycles);
    check_output("inflight_3000", 32'(p1_digits), 32'h5000);
    wait_done(cycles);
    wait_done(cycles);
    check_output("next_load_10", 32'(p1_digits), 32'h0010);

    // Reset during MIN restarts cleanly
    apply_stimulus(16'd3000, 16'd61, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    bus.player1_time = 16'd754;
    #1;
    check_output("mid_rst_p1", 32'(p1_digits), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_done(cycles);
    check_output("restart_754", 32'(p1_digits), 32'h1234);
    wait_done(cycles);
    check_output("restart_61", 32'(p2_digits), 32'h0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
